// File: rtl/psram_ctrl.sv
// -----------------------------------------------------------------------------
// psram_ctrl
//
// Memory-side responder for MemCtrl requests from HuCard mappers. Each CPU bus
// cycle carries at most one byte access. This block turns that access into one
// timed asynchronous PSRAM cycle on a 16-bit bus shared by two chips.
//
// A start is the rising edge of req_strobe while req_ce is high. The start
// takes effect on the same clock edge that first samples the strobe high.
// When the controller is busy, one start is held in a one-deep pending slot.
// A start that arrives while that slot is full is dropped, and the sticky ovr
// flag is set.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req_ce          the request targets this memory
//   req_strobe      CPU cycle strobe; its rising edge starts an access
//   req_oe, req_we  read / write request (write wins when both are set)
//   req_addr[23:0]  [23] chip select, [22:1] word address, [0] byte lane
//   req_dati[7:0]   write data
//   req_dato[7:0]   last byte read (holds between reads)
//   busy            an access or its recovery time is in progress
//   ovr             sticky flag: a start was dropped
//   mem_*           PSRAM pins: word address, chip enables, OE#, WE#, UB#,
//                   LB#, data in from the pads, data out to the pads, and the
//                   pad output enable
// -----------------------------------------------------------------------------
module psram_ctrl #(
    parameter int RD_CYC  = 4,  // clocks the read strobes are held (>=2)
    parameter int WR_CYC  = 4,  // clocks from access start to WE# release (>=2)
    parameter int REC_CYC = 2   // clocks of CE# high recovery (>=1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_ce,
    input  logic        req_strobe,
    input  logic        req_oe,
    input  logic        req_we,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_dati,
    output logic [7:0]  req_dato,
    output logic        busy,
    output logic        ovr,
    output logic [21:0] mem_addr,
    output logic [1:0]  mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_ub_n,
    output logic        mem_lb_n,
    input  logic [15:0] mem_dq_i,
    output logic [15:0] mem_dq_o,
    output logic        mem_dq_oe
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_REC  = 2'd3;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_CYC);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(REC_CYC - 1);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             strobe_q;
    logic             pend_q,      pend_d;
    logic             pend_we_q,   pend_we_d;
    logic [23:0]      pend_addr_q, pend_addr_d;
    logic [7:0]       pend_dati_q, pend_dati_d;
    logic             lane_q,      lane_d;
    logic [7:0]       dato_q,      dato_d;
    logic             busy_q,      busy_d;
    logic             ovr_q,       ovr_d;
    logic [21:0]      addr_q,      addr_d;
    logic [1:0]       ce_n_q,      ce_n_d;
    logic             oe_n_q,      oe_n_d;
    logic             we_n_q,      we_n_d;
    logic             ub_n_q,      ub_n_d;
    logic             lb_n_q,      lb_n_d;
    logic [15:0]      dq_o_q,      dq_o_d;
    logic             dq_oe_q,     dq_oe_d;

    logic        start;
    logic        launch;
    logic        l_we;
    logic [23:0] l_addr;
    logic [7:0]  l_dati;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_dati_d = pend_dati_q;
        lane_d      = lane_q;
        dato_d      = dato_q;
        ovr_d       = ovr_q;
        addr_d      = addr_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        ub_n_d      = ub_n_q;
        lb_n_d      = lb_n_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;

        // Rising strobe edge on this memory with a real operation requested.
        start  = req_strobe & ~strobe_q & req_ce & (req_oe | req_we);

        // The pending slot is the default launch source. A direct start from
        // IDLE overrides it below.
        launch = 1'b0;
        l_we   = pend_we_q;
        l_addr = pend_addr_q;
        l_dati = pend_dati_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    launch = 1'b1;
                    pend_d = 1'b0;
                end else if (start) begin
                    launch = 1'b1;
                    l_we   = req_we;
                    l_addr = req_addr;
                    l_dati = req_dati;
                end
            end
            ST_RD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == RD_LAST) begin
                    dato_d  = lane_q ? mem_dq_i[15:8] : mem_dq_i[7:0];
                    ce_n_d  = 2'b11;
                    oe_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    state_d = ST_REC;
                    cnt_d   = '0;
                end
            end
            ST_WR: begin
                cnt_d = cnt_q + 8'd1;
                // Pulling WE# low one clock after CE# gives the address and
                // data a clock of setup time.
                if (cnt_q == '0) begin
                    we_n_d = 1'b0;
                end
                if (cnt_q == WE_LAST) begin
                    we_n_d = 1'b1;
                end
                // CE#, the byte lanes and the pad drive stay asserted for one
                // clock after WE# rises, which gives the write its hold time.
                if (cnt_q == WR_LAST) begin
                    ce_n_d  = 2'b11;
                    ub_n_d  = 1'b1;
                    lb_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    state_d = ST_REC;
                    cnt_d   = '0;
                end
            end
            default: begin  // ST_REC
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == REC_LAST) begin
                    if (pend_q) begin
                        launch = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // A start while busy fills the pending slot. If the slot is already
        // full, the start is lost and reported through ovr. The full flag is
        // the registered one, so a slot that empties on this edge still counts
        // as full.
        if (start && (state_q != ST_IDLE || pend_q)) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                pend_we_d   = req_we;
                pend_addr_d = req_addr;
                pend_dati_d = req_dati;
            end
        end

        if (launch) begin
            state_d = l_we ? ST_WR : ST_RD;
            cnt_d   = '0;
            addr_d  = l_addr[22:1];
            ce_n_d  = l_addr[23] ? 2'b01 : 2'b10;
            lane_d  = l_addr[0];
            lb_n_d  = l_addr[0];
            ub_n_d  = ~l_addr[0];
            we_n_d  = 1'b1;
            if (l_we) begin
                oe_n_d  = 1'b1;
                dq_oe_d = 1'b1;
                dq_o_d  = {l_dati, l_dati};
            end else begin
                oe_n_d  = 1'b0;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_dati_q <= '0;
            lane_q      <= 1'b0;
            dato_q      <= '0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            addr_q      <= '0;
            ce_n_q      <= 2'b11;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strobe_q    <= req_strobe;
            pend_q      <= pend_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_dati_q <= pend_dati_d;
            lane_q      <= lane_d;
            dato_q      <= dato_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            addr_q      <= addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign req_dato  = dato_q;
    assign busy      = busy_q;
    assign ovr       = ovr_q;
    assign mem_addr  = addr_q;
    assign mem_ce_n  = ce_n_q;
    assign mem_oe_n  = oe_n_q;
    assign mem_we_n  = we_n_q;
    assign mem_ub_n  = ub_n_q;
    assign mem_lb_n  = lb_n_q;
    assign mem_dq_o  = dq_o_q;
    assign mem_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_psram_ctrl
//
// Self-checking bench for psram_ctrl.
//
// - A small PSRAM pad model drives mem_dq_i from the controller's pins.
// - A transaction-level reference model predicts every output on every cycle.
//   It tracks the access in flight as a start edge plus its length, and it
//   works out the strobe timing from the offset into that access.
// - Directed scenarios pin the model to hand-computed values.
// - A randomized phase then exercises pending starts, dropped starts and
//   read-after-write.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_psram_ctrl;

    localparam int RD_CYC  = 4;
    localparam int WR_CYC  = 4;
    localparam int REC_CYC = 2;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  dati;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ce, req_strobe, req_oe, req_we;
    logic [23:0] req_addr;
    logic [7:0]  req_dati;
    logic [7:0]  req_dato;
    logic        busy, ovr;
    logic [21:0] mem_addr;
    logic [1:0]  mem_ce_n;
    logic        mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
    logic [15:0] mem_dq_i;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psram_ctrl #(.RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .REC_CYC(REC_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_ce     (req_ce),
        .req_strobe (req_strobe),
        .req_oe     (req_oe),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_dati   (req_dati),
        .req_dato   (req_dato),
        .busy       (busy),
        .ovr        (ovr),
        .mem_addr   (mem_addr),
        .mem_ce_n   (mem_ce_n),
        .mem_oe_n   (mem_oe_n),
        .mem_we_n   (mem_we_n),
        .mem_ub_n   (mem_ub_n),
        .mem_lb_n   (mem_lb_n),
        .mem_dq_i   (mem_dq_i),
        .mem_dq_o   (mem_dq_o),
        .mem_dq_oe  (mem_dq_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- memory
    // Stimulus uses only word addresses 0..15 on each chip, so a 32-entry
    // array indexed by {chip, word[3:0]} covers every location.
    logic [15:0] psram   [32];
    logic [15:0] ref_mem [32];
    int          ce_cycles = 0;
    logic [1:0]  prev_ce   = 2'b11;

    always @(negedge clk) begin : pad_model
        logic       chip_ok;
        logic [4:0] i;
        chip_ok = (mem_ce_n == 2'b01) || (mem_ce_n == 2'b10);
        i       = {mem_ce_n == 2'b01, mem_addr[3:0]};
        if (chip_ok && !mem_we_n) begin
            if (!mem_lb_n) psram[i][7:0]  = mem_dq_o[7:0];
            if (!mem_ub_n) psram[i][15:8] = mem_dq_o[15:8];
        end
        mem_dq_i = (chip_ok && !mem_oe_n) ? psram[i] : 16'hDEAD;
        if (mem_ce_n != 2'b11 && prev_ce == 2'b11) ce_cycles++;
        prev_ce = mem_ce_n;
    end

    // ------------------------------------------------------ reference model
    int unsigned cyc;
    bit          m_prev, m_have, m_pend, m_ovr;
    req_t        m_act, m_pq;
    int unsigned m_s, m_end;
    logic [7:0]  m_dato;
    logic [21:0] m_addr;
    logic [15:0] m_dqo;

    task automatic launch(input req_t r, input int unsigned n);
        logic [4:0] i;
        m_have = 1'b1;
        m_act  = r;
        m_s    = n;
        m_end  = n + (r.we ? WR_CYC + 1 + REC_CYC : RD_CYC + REC_CYC);
        m_addr = r.addr[22:1];
        if (r.we) begin
            m_dqo = {r.dati, r.dati};
            i     = {r.addr[23], r.addr[4:1]};
            if (r.addr[0]) ref_mem[i][15:8] = r.dati;
            else           ref_mem[i][7:0]  = r.dati;
        end
    endtask

    always @(posedge clk) begin : model
        bit          start, busy_before, can_launch, pend_before;
        req_t        nr;
        int unsigned n;
        logic [15:0] w;
        if (rst) begin
            cyc = 0; m_prev = 0; m_have = 0; m_pend = 0; m_ovr = 0;
            m_dato = '0; m_addr = '0; m_dqo = '0;
        end else begin
            cyc++;
            n           = cyc;
            start       = req_strobe && !m_prev && req_ce && (req_oe || req_we);
            m_prev      = req_strobe;
            nr          = '{we: req_we, addr: req_addr, dati: req_dati};
            pend_before = m_pend;
            busy_before = (m_have && n <= m_end) || m_pend;
            can_launch  = !m_have || n >= m_end;
            if (m_have && !m_act.we && n == m_s + RD_CYC) begin
                w      = ref_mem[{m_act.addr[23], m_act.addr[4:1]}];
                m_dato = m_act.addr[0] ? w[15:8] : w[7:0];
            end
            if (can_launch && pend_before) begin
                launch(m_pq, n);
                m_pend = 0;
            end else if (can_launch && start && !busy_before) begin
                launch(nr, n);
            end
            if (start && busy_before) begin
                if (pend_before) m_ovr = 1;
                else begin m_pend = 1; m_pq = nr; end
            end
        end
    end

    // Compare every output on every falling edge; reset values apply while
    // rst is high.
    always @(negedge clk) begin : compare
        logic [1:0]  e_ce;
        logic        e_oe, e_we, e_ub, e_lb, e_dqoe, e_busy, e_ovr;
        logic [7:0]  e_dato;
        logic [21:0] e_addr;
        logic [15:0] e_dqo;
        int unsigned d;
        e_ce = 2'b11; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1; e_dqoe = 0; e_busy = 0;
        if (rst) begin
            e_ovr = 0; e_dato = '0; e_addr = '0; e_dqo = '0;
        end else begin
            e_ovr = m_ovr; e_dato = m_dato; e_addr = m_addr; e_dqo = m_dqo;
            if (m_have && cyc < m_end) begin
                d      = cyc - m_s;
                e_busy = 1;
                if (m_act.we ? (d <= WR_CYC) : (d < RD_CYC)) begin
                    e_ce = m_act.addr[23] ? 2'b01 : 2'b10;
                    e_lb = m_act.addr[0];
                    e_ub = !m_act.addr[0];
                    if (m_act.we) begin
                        e_dqoe = 1;
                        e_we   = !(d >= 1 && d < WR_CYC);
                    end else begin
                        e_oe = 0;
                    end
                end
            end
        end
        check("cmp_ce_n",  mem_ce_n,  e_ce);
        check("cmp_oe_n",  mem_oe_n,  e_oe);
        check("cmp_we_n",  mem_we_n,  e_we);
        check("cmp_ub_n",  mem_ub_n,  e_ub);
        check("cmp_lb_n",  mem_lb_n,  e_lb);
        check("cmp_dq_oe", mem_dq_oe, e_dqoe);
        check("cmp_busy",  busy,      e_busy);
        check("cmp_ovr",   ovr,       e_ovr);
        check("cmp_dato",  req_dato,  e_dato);
        check("cmp_addr",  mem_addr,  e_addr);
        check("cmp_dq_o",  mem_dq_o,  e_dqo);
    end

    // ------------------------------------------------------------- helpers
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic ce, input logic oe, input logic we,
                           input logic [23:0] addr, input logic [7:0] dati);
        req_ce = ce; req_oe = oe; req_we = we; req_addr = addr; req_dati = dati;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 200 && quiet < 3; i++) begin
            tick();
            quiet = busy ? 0 : quiet + 1;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int base;
        rst = 1'b1; req_strobe = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 24'h0, 8'h0);
        for (int i = 0; i < 32; i++) begin
            psram[i] = {8'(i + 8'h40), 8'(i ^ 8'hC3)};
        end
        psram[18] = 16'hA55A;  // chip 1, word 2
        for (int i = 0; i < 32; i++) ref_mem[i] = psram[i];

        repeat (3) tick();
        check("reset_ce_n", mem_ce_n, 2'b11);
        check("reset_busy", busy, 1'b0);
        check("reset_dato", req_dato, 8'h00);
        check("reset_dq_oe", mem_dq_oe, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // Read chip 1, word 2, upper lane.
        set_req(1'b1, 1'b1, 1'b0, 24'h800005, 8'h00);
        req_strobe = 1'b1;
        tick();                                   // after edge k
        check("rd_ce_n", mem_ce_n, 2'b01);
        check("rd_ub_n", mem_ub_n, 1'b0);
        check("rd_lb_n", mem_lb_n, 1'b1);
        check("rd_oe_n", mem_oe_n, 1'b0);
        check("rd_addr", mem_addr, 22'h2);
        req_strobe = 1'b0;
        repeat (3) tick();                        // k+3
        check("rd_dato_early", req_dato, 8'h00);
        tick();                                   // k+4
        check("rd_dato", req_dato, 8'hA5);
        check("rd_ce_rel", mem_ce_n, 2'b11);
        tick();                                   // k+5
        check("rd_busy_k5", busy, 1'b1);
        tick();                                   // k+6
        check("rd_busy_k6", busy, 1'b0);
        wait_idle();

        // Write 0x3C to chip 0, word 8, lower lane.
        set_req(1'b1, 1'b0, 1'b1, 24'h000010, 8'h3C);
        req_strobe = 1'b1;
        tick();                                   // k
        check("wr_dq_o", mem_dq_o, 16'h3C3C);
        check("wr_lb_n", mem_lb_n, 1'b0);
        check("wr_ce_n", mem_ce_n, 2'b10);
        check("wr_we_k0", mem_we_n, 1'b1);
        req_strobe = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check("wr_we_low", mem_we_n, 1'b0);
        end
        tick();                                   // k+4
        check("wr_we_k4", mem_we_n, 1'b1);
        check("wr_ce_k4", mem_ce_n, 2'b10);
        tick();                                   // k+5
        check("wr_ce_k5", mem_ce_n, 2'b11);
        check("wr_dqoe_k5", mem_dq_oe, 1'b0);
        wait_idle();

        // Back-to-back reads; the second one starts at k+2.
        set_req(1'b1, 1'b1, 1'b0, 24'h800004, 8'h00);
        req_strobe = 1'b1;
        tick();                                   // k
        req_strobe = 1'b0;
        tick();                                   // k+1
        req_addr = 24'h000010;
        req_strobe = 1'b1;
        tick();                                   // k+2
        req_strobe = 1'b0;
        check("b2b_ovr", ovr, 1'b0);
        repeat (2) tick();                        // k+4
        check("b2b_dato1", req_dato, 8'h5A);
        check("b2b_rec", mem_ce_n, 2'b11);
        tick();                                   // k+5
        check("b2b_busy_k5", busy, 1'b1);
        tick();                                   // k+6
        check("b2b_ce2", mem_ce_n, 2'b10);
        check("b2b_addr2", mem_addr, 22'h8);
        check("b2b_busy_k6", busy, 1'b1);
        repeat (4) tick();                        // k+10
        check("b2b_dato2", req_dato, 8'h3C);
        wait_idle();
        check("b2b_ovr_end", ovr, 1'b0);

        // Overrun: three starts inside one read.
        base = ce_cycles;
        set_req(1'b1, 1'b1, 1'b0, 24'h800005, 8'h00);
        for (int s = 0; s < 3; s++) begin
            req_strobe = 1'b1;
            tick();
            req_strobe = 1'b0;
            if (s == 1) check("ovr_after2", ovr, 1'b0);
            if (s < 2) tick();
        end
        check("ovr_set", ovr, 1'b1);
        wait_idle();
        check("ovr_cycles", ce_cycles - base, 2);

        // Starts that must be ignored: req_ce low, then no operation.
        set_req(1'b0, 1'b1, 1'b0, 24'h800005, 8'h00);
        req_strobe = 1'b1;
        tick();
        check("nce_busy", busy, 1'b0);
        check("nce_ce_n", mem_ce_n, 2'b11);
        req_strobe = 1'b0;
        tick();
        set_req(1'b1, 1'b0, 1'b0, 24'h800005, 8'h00);
        req_strobe = 1'b1;
        tick();
        req_strobe = 1'b0;
        tick();
        check("nop_busy", busy, 1'b0);
        check("nop_ce_n", mem_ce_n, 2'b11);

        // Asynchronous reset at k+2 of a write.
        set_req(1'b1, 1'b0, 1'b1, 24'h00000C, 8'h77);
        req_strobe = 1'b1;
        tick();                                   // k
        req_strobe = 1'b0;
        repeat (2) tick();                        // k+2
        check("rstw_we_low", mem_we_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rstw_we_n", mem_we_n, 1'b1);
        check("rstw_ce_n", mem_ce_n, 2'b11);
        check("rstw_dq_oe", mem_dq_oe, 1'b0);
        check("rstw_ovr", ovr, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("rstw_idle", busy, 1'b0);
        check("rstw_ce_idle", mem_ce_n, 2'b11);

        // Random traffic: dense starts first, then sparse ones.
        for (int i = 0; i < 4000; i++) begin
            req_ce = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, (i < 2000) ? 2 : 7) == 0) req_strobe = ~req_strobe;
            req_oe   = 1'($urandom_range(0, 1));
            req_we   = ($urandom_range(0, 2) == 0);
            req_addr = {1'($urandom), 18'd0, 4'($urandom), 1'($urandom)};
            req_dati = 8'($urandom);
            tick();
        end
        req_strobe = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
